light_pattern_sequencer: RTL and testbench

LIGHT_PATTERN_SEQUENCER -- requirements
Module: light_pattern_sequencer

---
 rtl/light_show_pkg.sv | 39 +++
 rtl/key_conditioner.sv | 67 ++++++
 rtl/light_pattern_sequencer.sv | 122 ++++++++++++
 tb/tb_light_pattern_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/light_show_pkg.sv
// Shared types and constants for the light pattern sequencer.
// led_image() maps a pattern/position pair onto the red LED bar.
package light_show_pkg;

  localparam int LED_RED_W = 10;
  localparam int LED_GRN_W = 8;
  localparam int FILL_LAST = 10;

  typedef enum logic {
    RUN    = 1'b0,
    PAUSED = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    CHASE  = 2'd0,
    BOUNCE = 2'd1,
    FILL   = 2'd2,
    BINARY = 2'd3
  } pattern_t;

  function automatic logic [LED_RED_W-1:0] led_image(input pattern_t pat, input logic [9:0] pos);
    logic [LED_RED_W-1:0] img;
    img = '0;
    case (pat)
      BINARY: img = pos;
      FILL: begin
        // pos == FILL_LAST is the blank frame between sweeps
        for (int i = 0; i < LED_RED_W; i++)
          img[i] = (10'(i) <= pos) && (pos != 10'(FILL_LAST));
      end
      default: begin
        for (int i = 0; i < LED_RED_W; i++)
          img[i] = (pos == 10'(i));
      end
    endcase
    return img;
  endfunction

endpackage

// File: rtl/key_conditioner.sv
// Active-low key -> one-cycle press pulse: 2-flop sync, optional debounce
// (LIGHT_SHOW_DEBOUNCE_EN), falling-edge detect; pulse 3 (or DEBOUNCE_CYCLES+3) cycles after the fall.
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_press
);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_prev;
  logic       r_armed;
  logic       r_press;
  logic [1:0] r_vld;
  logic       w_level;

`ifdef LIGHT_SHOW_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic [CW-1:0] r_db_cnt;
  logic          r_stable;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_db_cnt <= '0;
      r_stable <= 1'b1;
    end else if (r_sync2 == r_stable) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      r_stable <= r_sync2;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  assign w_level = r_stable;
`else
  assign w_level = r_sync2;
`endif

  // r_vld marks when r_sync2 holds a real post-reset sample; a key must be
  // seen released before its next fall counts, so a key held through reset is ignored.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
      r_vld   <= 2'b00;
      r_armed <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      r_prev  <= w_level;
      r_vld   <= {r_vld[0], 1'b1};
      r_armed <= r_armed | (r_vld[1] & r_sync2);
      r_press <= r_armed & r_prev & ~w_level;
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/light_pattern_sequencer.sv
// Key-driven LED pattern sequencer; StepTick is combinational, LED outputs update one cycle after a step.
// Key debounce is enabled by defining LIGHT_SHOW_DEBOUNCE_EN.
module light_pattern_sequencer
  import light_show_pkg::*;
#(
  parameter int BASE_DIV        = 2_500_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [3:0]           Keys,
  input  logic [9:0]           Switches,
  output logic [LED_RED_W-1:0] LedRed,
  output logic [LED_GRN_W-1:0] LedGrn,
  output logic                 StepTick
);

  localparam logic [9:0] POS_LAST  = 10'd9;
  localparam logic [9:0] FILL_END  = 10'(FILL_LAST);

  logic [3:0] w_press;

  for (genvar g = 0; g < 4; g++) begin : g_key
    key_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .i_clk   (Clock),
      .i_rst   (Reset),
      .i_key_n (Keys[g]),
      .o_press (w_press[g])
    );
  end

  state_t               r_state;
  pattern_t             r_pat;
  logic [9:0]           r_pos;
  logic                 r_dir;
  logic [31:0]          r_cnt;
  logic [LED_RED_W-1:0] r_led_red;
  logic [LED_GRN_W-1:0] r_led_grn;

  logic [31:0] w_period_m1;
  logic        w_due;
  logic        w_step;
  logic        w_dir_eff;
  state_t      w_state_nxt;
  pattern_t    w_pat_nxt;
  logic [9:0]  w_pos_nxt;
  logic        w_dir_nxt;

  assign w_period_m1 = 32'(BASE_DIV) * (32'(Switches[3:0]) + 32'd1) - 32'd1;
  assign w_due       = (r_state == RUN) && (r_cnt >= w_period_m1);
  // A pattern change on Key1 swallows any step decided in the same cycle
  assign w_step      = ~w_press[1] & (w_due | ((r_state == PAUSED) & w_press[3]));
  assign w_dir_eff   = r_dir ^ w_press[2];
  assign w_state_nxt = w_press[0] ? ((r_state == RUN) ? PAUSED : RUN) : r_state;

  always_comb begin
    w_pat_nxt = r_pat;
    w_pos_nxt = r_pos;
    w_dir_nxt = w_dir_eff;
    if (w_press[1]) begin
      w_pat_nxt = pattern_t'(r_pat + 2'd1);
      w_pos_nxt = '0;
    end else if (w_step) begin
      case (r_pat)
        CHASE: begin
          if (!w_dir_eff) w_pos_nxt = (r_pos >= POS_LAST) ? 10'd0 : r_pos + 10'd1;
          else            w_pos_nxt = (r_pos == 10'd0) ? POS_LAST : r_pos - 10'd1;
        end
        BOUNCE: begin
          if (!w_dir_eff) begin
            if (r_pos >= POS_LAST) begin
              w_pos_nxt = POS_LAST - 10'd1;
              w_dir_nxt = 1'b1;
            end else begin
              w_pos_nxt = r_pos + 10'd1;
            end
          end else begin
            if (r_pos == 10'd0) begin
              w_pos_nxt = 10'd1;
              w_dir_nxt = 1'b0;
            end else begin
              w_pos_nxt = r_pos - 10'd1;
            end
          end
        end
        FILL: begin
          if (!w_dir_eff) w_pos_nxt = (r_pos >= FILL_END) ? 10'd0 : r_pos + 10'd1;
          else            w_pos_nxt = (r_pos == 10'd0) ? FILL_END : r_pos - 10'd1;
        end
        default: w_pos_nxt = w_dir_eff ? r_pos - 10'd1 : r_pos + 10'd1;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state   <= RUN;
      r_pat     <= CHASE;
      r_pos     <= '0;
      r_dir     <= 1'b0;
      r_cnt     <= '0;
      r_led_red <= 10'b0000000001;
      r_led_grn <= {Switches[3:0], 1'b0, 1'b1, 2'b00};
    end else begin
      r_state   <= w_state_nxt;
      r_pat     <= w_pat_nxt;
      r_pos     <= w_pos_nxt;
      r_dir     <= w_dir_nxt;
      if ((r_state != RUN) || w_press[0] || w_due) r_cnt <= '0;
      else                                          r_cnt <= r_cnt + 32'd1;
      r_led_red <= led_image(w_pat_nxt, w_pos_nxt);
      r_led_grn <= {Switches[3:0], w_dir_nxt, (w_state_nxt == RUN), w_pat_nxt};
    end
  end

  assign StepTick = w_step & ~Reset;
  assign LedRed   = r_led_red;
  assign LedGrn   = r_led_grn;

endmodule

// File: tb/tb_light_pattern_sequencer.sv
// Directed bench for light_pattern_sequencer with BASE_DIV=4, DEBOUNCE_CYCLES=3.
module tb_light_pattern_sequencer;

  localparam int BASE_DIV = 4;
  localparam int DEB      = 3;
`ifdef LIGHT_SHOW_DEBOUNCE_EN
  localparam int LAT = DEB + 3;
`else
  localparam int LAT = 3;
`endif

  logic       Clock = 1'b0;
  logic       Reset;
  logic [3:0] Keys;
  logic [9:0] Switches;
  logic [9:0] LedRed;
  logic [7:0] LedGrn;
  logic       StepTick;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clock = ~Clock;

  light_pattern_sequencer #(
    .BASE_DIV        (BASE_DIV),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Keys     (Keys),
    .Switches (Switches),
    .LedRed   (LedRed),
    .LedGrn   (LedGrn),
    .StepTick (StepTick)
  );

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Leaves the bench one step after the reset edge, rate count at 0
  task automatic do_reset();
    Reset = 1'b1;
    Keys  = 4'hF;
    tick();
    Reset = 1'b0;
  endtask

  task automatic press_key(input int n);
    Keys[n] = 1'b0;
    ticks(LAT + 1);
    Keys[n] = 1'b1;
    ticks(LAT + 3);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Keys = 4'hF;
    Switches = 10'h3C5;
    ticks(2);
    n_checks++;
    if (LedRed !== 10'h001) begin n_fail++; $display("FAIL reset_ledred: got %h want 001", LedRed); end
    n_checks++;
    if (LedGrn !== 8'h54) begin n_fail++; $display("FAIL reset_ledgrn: got %h want 54", LedGrn); end
    n_checks++;
    if (StepTick !== 1'b0) begin n_fail++; $display("FAIL reset_steptick: got %b want 0", StepTick); end
    Switches = 10'h000;
  endtask

  task automatic test_chase();
    logic [9:0] exp_led;
    logic       exp_tick;
    do_reset();
    n_checks++;
    if (LedGrn !== 8'h04) begin n_fail++; $display("FAIL chase_grn0: got %h want 04", LedGrn); end
    for (int k = 0; k <= 40; k++) begin
      exp_led  = 10'h001 << ((k / 4) % 10);
      exp_tick = ((k % 4) == 3);
      n_checks++;
      if (StepTick !== exp_tick) begin n_fail++; $display("FAIL chase_tick k=%0d: got %b want %b", k, StepTick, exp_tick); end
      n_checks++;
      if (LedRed !== exp_led) begin n_fail++; $display("FAIL chase_led k=%0d: got %h want %h", k, LedRed, exp_led); end
      tick();
    end
  endtask

  task automatic test_key1_vs_step();
    do_reset();
    ticks(7 - LAT);
    Keys[1] = 1'b0;
    ticks(LAT);
    n_checks++;
    if (StepTick !== 1'b0) begin n_fail++; $display("FAIL key1_drop_tick: got %b want 0", StepTick); end
    tick();
    n_checks++;
    if (LedRed !== 10'h001) begin n_fail++; $display("FAIL key1_led: got %h want 001", LedRed); end
    n_checks++;
    if (LedGrn[1:0] !== 2'd1) begin n_fail++; $display("FAIL key1_pattern: got %0d want 1", LedGrn[1:0]); end
    Keys[1] = 1'b1;
    ticks(36);
    n_checks++;
    if (LedRed !== 10'h200) begin n_fail++; $display("FAIL bounce_top: got %h want 200", LedRed); end
    n_checks++;
    if (LedGrn[3] !== 1'b0) begin n_fail++; $display("FAIL bounce_dir_before: got %b want 0", LedGrn[3]); end
    ticks(4);
    n_checks++;
    if (LedRed !== 10'h100) begin n_fail++; $display("FAIL bounce_back1: got %h want 100", LedRed); end
    n_checks++;
    if (LedGrn[3] !== 1'b1) begin n_fail++; $display("FAIL bounce_dir_after: got %b want 1", LedGrn[3]); end
    ticks(4);
    n_checks++;
    if (LedRed !== 10'h080) begin n_fail++; $display("FAIL bounce_back2: got %h want 080", LedRed); end
  endtask

  task automatic test_dir_with_step();
    do_reset();
    ticks(7 - LAT);
    Keys[2] = 1'b0;
    ticks(LAT);
    n_checks++;
    if (StepTick !== 1'b1) begin n_fail++; $display("FAIL dir_step_tick: got %b want 1", StepTick); end
    tick();
    n_checks++;
    if (LedRed !== 10'h001) begin n_fail++; $display("FAIL dir_step_led: got %h want 001", LedRed); end
    n_checks++;
    if (LedGrn[3] !== 1'b1) begin n_fail++; $display("FAIL dir_step_grn: got %b want 1", LedGrn[3]); end
    Keys[2] = 1'b1;
    ticks(4);
    n_checks++;
    if (LedRed !== 10'h200) begin n_fail++; $display("FAIL dir_wrap_down: got %h want 200", LedRed); end
  endtask

  task automatic test_pause();
    int cnt;
    do_reset();
    ticks(7 - LAT);
    Keys[0] = 1'b0;
    ticks(LAT);
    n_checks++;
    if (StepTick !== 1'b1) begin n_fail++; $display("FAIL pause_step_taken: got %b want 1", StepTick); end
    tick();
    n_checks++;
    if (LedGrn[2] !== 1'b0) begin n_fail++; $display("FAIL pause_run_bit: got %b want 0", LedGrn[2]); end
    n_checks++;
    if (LedRed !== 10'h004) begin n_fail++; $display("FAIL pause_led: got %h want 004", LedRed); end
    Keys[0] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      cnt += int'(StepTick);
    end
    n_checks++;
    if (cnt !== 0) begin n_fail++; $display("FAIL pause_no_steps: got %0d steps want 0", cnt); end
    Keys[3] = 1'b0;
    cnt = 0;
    for (int i = 0; i < LAT + 5; i++) begin
      tick();
      cnt += int'(StepTick);
      if (i == LAT) Keys[3] = 1'b1;
    end
    n_checks++;
    if (cnt !== 1) begin n_fail++; $display("FAIL key3_one_step: got %0d steps want 1", cnt); end
    n_checks++;
    if (LedRed !== 10'h008) begin n_fail++; $display("FAIL key3_led: got %h want 008", LedRed); end
    press_key(0);
    n_checks++;
    if (LedGrn[2] !== 1'b1) begin n_fail++; $display("FAIL resume_run_bit: got %b want 1", LedGrn[2]); end
  endtask

  task automatic test_binary();
    do_reset();
    ticks(4);
    press_key(0);
    for (int i = 0; i < 3; i++) press_key(1);
    n_checks++;
    if (LedRed !== 10'h000) begin n_fail++; $display("FAIL bin_start: got %h want 000", LedRed); end
    n_checks++;
    if (LedGrn[2:0] !== 3'b011) begin n_fail++; $display("FAIL bin_grn: got %b want 011", LedGrn[2:0]); end
    press_key(2);
    n_checks++;
    if (LedGrn !== 8'h0B) begin n_fail++; $display("FAIL bin_dir_grn: got %h want 0B", LedGrn); end
    press_key(3);
    n_checks++;
    if (LedRed !== 10'h3FF) begin n_fail++; $display("FAIL bin_down_wrap: got %h want 3FF", LedRed); end
    press_key(3);
    n_checks++;
    if (LedRed !== 10'h3FE) begin n_fail++; $display("FAIL bin_down: got %h want 3FE", LedRed); end
    press_key(2);
    press_key(3);
    n_checks++;
    if (LedRed !== 10'h3FF) begin n_fail++; $display("FAIL bin_up: got %h want 3FF", LedRed); end
    press_key(3);
    n_checks++;
    if (LedRed !== 10'h000) begin n_fail++; $display("FAIL bin_up_wrap: got %h want 000", LedRed); end
  endtask

  task automatic test_fill();
    do_reset();
    ticks(4);
    press_key(0);
    press_key(1);
    press_key(1);
    n_checks++;
    if (LedRed !== 10'h001) begin n_fail++; $display("FAIL fill_start: got %h want 001", LedRed); end
    n_checks++;
    if (LedGrn[1:0] !== 2'd2) begin n_fail++; $display("FAIL fill_pattern: got %0d want 2", LedGrn[1:0]); end
    press_key(3);
    n_checks++;
    if (LedRed !== 10'h003) begin n_fail++; $display("FAIL fill_pos1: got %h want 003", LedRed); end
    press_key(2);
    press_key(3);
    n_checks++;
    if (LedRed !== 10'h001) begin n_fail++; $display("FAIL fill_back0: got %h want 001", LedRed); end
    press_key(3);
    n_checks++;
    if (LedRed !== 10'h000) begin n_fail++; $display("FAIL fill_rev_blank: got %h want 000", LedRed); end
    press_key(3);
    n_checks++;
    if (LedRed !== 10'h3FF) begin n_fail++; $display("FAIL fill_full: got %h want 3FF", LedRed); end
    press_key(2);
    press_key(3);
    n_checks++;
    if (LedRed !== 10'h000) begin n_fail++; $display("FAIL fill_fwd_blank: got %h want 000", LedRed); end
    press_key(3);
    n_checks++;
    if (LedRed !== 10'h001) begin n_fail++; $display("FAIL fill_wrap: got %h want 001", LedRed); end
  endtask

  task automatic test_rate();
    Switches = 10'h001;
    do_reset();
    n_checks++;
    if (LedGrn !== 8'h14) begin n_fail++; $display("FAIL rate_grn: got %h want 14", LedGrn); end
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (StepTick !== (k == 7)) begin n_fail++; $display("FAIL rate_tick k=%0d: got %b want %b", k, StepTick, (k == 7)); end
      tick();
    end
    n_checks++;
    if (LedRed !== 10'h002) begin n_fail++; $display("FAIL rate_led1: got %h want 002", LedRed); end
    ticks(4);
    n_checks++;
    if (StepTick !== 1'b0) begin n_fail++; $display("FAIL rate_mid_idle: got %b want 0", StepTick); end
    Switches = 10'h000;
    #1;
    n_checks++;
    if (StepTick !== 1'b1) begin n_fail++; $display("FAIL rate_lower_fires: got %b want 1", StepTick); end
    tick();
    n_checks++;
    if (LedRed !== 10'h004) begin n_fail++; $display("FAIL rate_led2: got %h want 004", LedRed); end
    n_checks++;
    if (LedGrn[7:4] !== 4'h0) begin n_fail++; $display("FAIL rate_grn_r: got %h want 0", LedGrn[7:4]); end
  endtask

  task automatic test_reset_override();
    do_reset();
    ticks(3);
    Reset = 1'b1;
    #1;
    n_checks++;
    if (StepTick !== 1'b0) begin n_fail++; $display("FAIL rst_over_tick: got %b want 0", StepTick); end
    tick();
    n_checks++;
    if (LedRed !== 10'h001) begin n_fail++; $display("FAIL rst_over_led: got %h want 001", LedRed); end
    n_checks++;
    if (LedGrn !== 8'h04) begin n_fail++; $display("FAIL rst_over_grn: got %h want 04", LedGrn); end
    Reset = 1'b0;
  endtask

  task automatic test_held_key();
    Reset = 1'b1;
    Keys = 4'hD;
    ticks(2);
    Reset = 1'b0;
    ticks(12);
    n_checks++;
    if (LedGrn[1:0] !== 2'd0) begin n_fail++; $display("FAIL held_key_ignored: got %0d want 0", LedGrn[1:0]); end
    Keys[1] = 1'b1;
    ticks(LAT + 3);
    press_key(1);
    n_checks++;
    if (LedGrn[1:0] !== 2'd1) begin n_fail++; $display("FAIL held_key_repress: got %0d want 1", LedGrn[1:0]); end
  endtask

`ifdef LIGHT_SHOW_DEBOUNCE_EN
  task automatic test_debounce();
    do_reset();
    ticks(4);
    Keys[1] = 1'b0;
    ticks(2);
    Keys[1] = 1'b1;
    ticks(12);
    n_checks++;
    if (LedGrn[1:0] !== 2'd0) begin n_fail++; $display("FAIL deb_glitch: got %0d want 0", LedGrn[1:0]); end
    Keys[1] = 1'b0;
    ticks(LAT);
    n_checks++;
    if (LedGrn[1:0] !== 2'd0) begin n_fail++; $display("FAIL deb_early: got %0d want 0", LedGrn[1:0]); end
    tick();
    n_checks++;
    if (LedGrn[1:0] !== 2'd1) begin n_fail++; $display("FAIL deb_press: got %0d want 1", LedGrn[1:0]); end
    Keys[1] = 1'b1;
    ticks(LAT + 3);
  endtask
`endif

  initial begin
    Reset    = 1'b1;
    Keys     = 4'hF;
    Switches = 10'h000;
    test_reset();
    test_chase();
    test_key1_vs_step();
    test_dir_with_step();
    test_pause();
    test_binary();
    test_fill();
    test_rate();
    test_reset_override();
    test_held_key();
`ifdef LIGHT_SHOW_DEBOUNCE_EN
    test_debounce();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
